l1_mem_arbiter: RTL and testbench

Shares the single block-wide data memory (16-bit block address, 128-bit block, ren/wen/ready/done handshake) between the L1 data cache (port 0) and the L1 instruction cache (port 1).
- Grants one requester at a time, round-robin.
- Sequences the memory strobes, including the mandatory strobe-low gap between accesses.
- Returns read data with a one-cycle done pulse.
- A watchdog aborts accesses the memory never completes.
- Sits between the two cache controllers and the memory instance.

---
 rtl/l1_mem_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 30 +++
 rtl/l1_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_mem_pkg.sv
// l1_mem_pkg
// Shared definitions for the L1 memory arbiter slice: arbiter FSM state
// encoding, default address/data widths and the requester port ids.
package l1_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 128;

  // Requester ids: port 0 is the data cache, port 1 the instruction cache
  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Combinational two-way round-robin pick.
// Ports:
//   r0, r1      in  request from port 0 / port 1
//   last_grant  in  id of the port served most recently
//   grant       out id of the chosen port (meaningful when valid=1)
//   valid       out at least one port is requesting
module rr_arbiter2
  import l1_mem_pkg::*;
(
  input  logic r0,
  input  logic r1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  // A lone requester always wins; on a tie the port that was not served
  // last goes next, which makes back-to-back contention alternate.
  always_comb begin
    grant = PORT_D;
    valid = r0 | r1;
    if (r0 && r1) begin
      grant = ~last_grant;
    end else if (r1) begin
      grant = PORT_I;
    end
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
// Shares one block-wide data memory between the L1 dcache (port 0) and the
// L1 icache (port 1). One access at a time, round-robin between the two,
// with a forced strobe-low cycle after every access and a watchdog that
// aborts accesses the memory never completes.
// Ports:
//   clock, reset                     rising-edge clock, synchronous active-high reset
//   p0_ren/p0_wen/p0_addr/p0_din     dcache request (level, held until p0_done)
//   p0_dout/p0_done                  dcache read data and one-cycle completion pulse
//   p1_ren/p1_addr                   icache read request
//   p1_dout/p1_done                  icache read data and one-cycle completion pulse
//   mem_ren/mem_wen/mem_addr/mem_din memory strobes, address and write data
//   mem_ready/mem_done/mem_dout      memory idle flag, completion and read data
//   err_timeout                      sticky watchdog flag, cleared only by reset
module l1_mem_arbiter
  import l1_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_ren,
  input  logic              p0_wen,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_din,
  output logic [DATA_W-1:0] p0_dout,
  output logic              p0_done,
  input  logic              p1_ren,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic [DATA_W-1:0] p1_dout,
  output logic              p1_done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              err_timeout
);

  // The counter only has to reach TIMEOUT-1: ACCESS lasts at most TIMEOUT cycles
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              grant_id;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] dout0_q;
  logic [DATA_W-1:0] dout1_q;
  logic [WD_W-1:0]   wd_cnt;
  logic              err_q;
  logic              rr_grant;
  logic              rr_valid;
  logic              grant_now;
  logic              wd_expire;

  rr_arbiter2 u_rr (
    .r0         (p0_ren | p0_wen),
    .r1         (p1_ren),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .valid      (rr_valid)
  );

  assign grant_now = (state == IDLE) && mem_ready && rr_valid;
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  // State register; reset abandons any access in flight without a done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A completion in the same cycle as watchdog expiry
  // still counts as a normal completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_now) state_nxt = ACCESS;
      ACCESS:  if (mem_done || wd_expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode from registered state and latched op only, so strobes
  // never depend combinationally on requester or memory inputs. RESP keeps
  // both strobes low, giving the memory its mandatory gap.
  always_comb begin
    mem_ren = (state == ACCESS) && !op_wr;
    mem_wen = (state == ACCESS) && op_wr;
    p0_done = (state == RESP) && (grant_id == PORT_D);
    p1_done = (state == RESP) && (grant_id == PORT_I);
  end

  assign mem_addr    = addr_q;
  assign mem_din     = din_q;
  assign p0_dout     = dout0_q;
  assign p1_dout     = dout1_q;
  assign err_timeout = err_q;

  // Request latch, read-data capture, fairness pointer and watchdog.
  // last_grant resets to the icache so the dcache wins the first tie.
  // A p0 request with both ren and wen set is treated as a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= PORT_I;
      grant_id   <= PORT_D;
      op_wr      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      dout0_q    <= '0;
      dout1_q    <= '0;
      wd_cnt     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (grant_now) begin
            grant_id <= rr_grant;
            op_wr    <= (rr_grant == PORT_D) && p0_wen;
            addr_q   <= (rr_grant == PORT_D) ? p0_addr : p1_addr;
            din_q    <= (rr_grant == PORT_D) ? p0_din : '0;
          end
        end
        ACCESS: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (mem_done) begin
            if (!op_wr) begin
              if (grant_id == PORT_D) dout0_q <= mem_dout;
              else                    dout1_q <= mem_dout;
            end
          end else if (wd_expire) begin
            err_q <= 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant_id;
          wd_cnt     <= '0;
        end
        default: wd_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter
// Directed bench for l1_mem_arbiter. A default instance (TIMEOUT=1023) and a
// second instance with TIMEOUT=50 share the requester inputs; a small memory
// model answers whichever instance is currently selected.
module tb_l1_mem_arbiter;

  logic         clock;
  logic         reset;
  logic         p0_ren, p0_wen, p1_ren;
  logic [15:0]  p0_addr, p1_addr;
  logic [127:0] p0_din;
  logic         mem_ready;
  logic         mem_done;
  logic [127:0] mem_dout;

  logic [127:0] a_p0_dout, a_p1_dout, a_mem_din, b_p0_dout, b_p1_dout, b_mem_din;
  logic [15:0]  a_mem_addr, b_mem_addr;
  logic         a_p0_done, a_p1_done, a_mem_ren, a_mem_wen, a_err;
  logic         b_p0_done, b_p1_done, b_mem_ren, b_mem_wen, b_err;

  // Selected-instance view used by the memory model, monitor and checks
  bit           sel_wd;
  logic         s_ren, s_wen, s_p0_done, s_p1_done, s_err;
  logic [15:0]  s_addr;
  logic [127:0] s_din, s_p0_dout, s_p1_dout;

  localparam logic [127:0] DEAD4 = {16'hDEAD, 96'd0, 16'h0004};

  int  checks = 0;
  int  passes = 0;
  int  lat = 4;
  bit  never_done = 0;
  bit  preload = 1;
  int  mcnt;

  l1_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_ren(p0_ren), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_dout(a_p0_dout), .p0_done(a_p0_done),
    .p1_ren(p1_ren), .p1_addr(p1_addr), .p1_dout(a_p1_dout), .p1_done(a_p1_done),
    .mem_ren(a_mem_ren), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout),
    .err_timeout(a_err)
  );

  l1_mem_arbiter #(.TIMEOUT(50)) dut_wd (
    .clock(clock), .reset(reset),
    .p0_ren(p0_ren), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_din(p0_din),
    .p0_dout(b_p0_dout), .p0_done(b_p0_done),
    .p1_ren(p1_ren), .p1_addr(p1_addr), .p1_dout(b_p1_dout), .p1_done(b_p1_done),
    .mem_ren(b_mem_ren), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_dout(mem_dout),
    .err_timeout(b_err)
  );

  assign s_ren     = sel_wd ? b_mem_ren  : a_mem_ren;
  assign s_wen     = sel_wd ? b_mem_wen  : a_mem_wen;
  assign s_addr    = sel_wd ? b_mem_addr : a_mem_addr;
  assign s_din     = sel_wd ? b_mem_din  : a_mem_din;
  assign s_p0_done = sel_wd ? b_p0_done  : a_p0_done;
  assign s_p1_done = sel_wd ? b_p1_done  : a_p1_done;
  assign s_p0_dout = sel_wd ? b_p0_dout  : a_p0_dout;
  assign s_p1_dout = sel_wd ? b_p1_dout  : a_p1_dout;
  assign s_err     = sel_wd ? b_err      : a_err;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  // Memory model: completes on the lat-th consecutive strobe cycle, shares the reset
  logic [127:0] mem_arr [256];

  always @(posedge clock) begin
    if (reset || !(s_ren || s_wen)) mcnt <= 0;
    else                            mcnt <= mcnt + 1;
  end

  assign mem_done = (s_ren || s_wen) && !never_done && (mcnt == lat - 1);
  assign mem_dout = mem_arr[s_addr[7:0]];

  always @(posedge clock) begin
    if (preload) begin
      mem_arr[8'h04] <= DEAD4;
      mem_arr[8'h10] <= 128'h5555;
      mem_arr[8'h20] <= 128'h7777;
    end else if (s_wen && mem_done) begin
      mem_arr[s_addr[7:0]] <= s_din;
    end
  end

  // Strobe monitor: run length, op and address of the current access, the
  // strobe-low gap in front of it, overlap and address-stability violations.
  int          run_len = 0, gap_cnt = 100, last_gap = 100, overlap = 0, unstable = 0;
  int          done0_cnt = 0, done1_cnt = 0;
  bit          prev_strobe = 0, seen_ren = 0, seen_wen = 0;
  logic [15:0] seen_addr = '0;

  always @(negedge clock) begin
    if (s_ren || s_wen) begin
      if (!prev_strobe) begin
        last_gap = gap_cnt;
        run_len  = 0;
        seen_ren = 0;
        seen_wen = 0;
      end else if (s_addr != seen_addr) begin
        unstable++;
      end
      run_len++;
      if (s_ren) seen_ren = 1;
      if (s_wen) seen_wen = 1;
      if (s_ren && s_wen) overlap++;
      seen_addr = s_addr;
      gap_cnt   = 0;
    end else begin
      gap_cnt++;
    end
    prev_strobe = s_ren || s_wen;
    if (s_p0_done) done0_cnt++;
    if (s_p1_done) done1_cnt++;
  end

  typedef struct {
    logic         p0_ren;
    logic         p0_wen;
    logic [15:0]  p0_addr;
    logic [127:0] p0_din;
    logic         p1_ren;
    logic [15:0]  p1_addr;
    int           lat;
    int           exp_port;
    logic         exp_wen;
    logic [15:0]  exp_addr;
    logic [127:0] exp_d0;
    logic [127:0] exp_d1;
  } vec_t;

  vec_t vecs[5];

  // Drive and sample one time unit after the falling edge
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    else
      passes++;
  endtask

  task automatic waitDone(input int budget, output int port);
    port = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_p0_done) begin port = 0; break; end
      if (s_p1_done) begin port = 1; break; end
    end
    if (port < 0) checkOutput("done_wait", 0, 1);
  endtask

  task automatic dropAll();
    p0_ren = 0;
    p0_wen = 0;
    p1_ren = 0;
  endtask

  task automatic doReset();
    tick();
    reset = 1;
    dropAll();
    tick();
    tick();
    reset = 0;
  endtask

  // Issue one transaction and check it
  task automatic applyStimulus(input vec_t v, input string tag);
    int port;
    tick();
    p0_ren  = v.p0_ren;
    p0_wen  = v.p0_wen;
    p0_addr = v.p0_addr;
    p0_din  = v.p0_din;
    p1_ren  = v.p1_ren;
    p1_addr = v.p1_addr;
    lat     = v.lat;
    waitDone(v.lat + 20, port);
    dropAll();
    checkOutput({tag, "_port"}, 128'(port), 128'(v.exp_port));
    checkOutput({tag, "_len"}, 128'(run_len), 128'(v.lat));
    checkOutput({tag, "_op"}, {126'd0, seen_ren, seen_wen}, {126'd0, !v.exp_wen, v.exp_wen});
    checkOutput({tag, "_addr"}, 128'(seen_addr), 128'(v.exp_addr));
    checkOutput({tag, "_gap"}, 128'(last_gap >= 2), 128'(1));
    tick();
    checkOutput({tag, "_pulse"}, {126'd0, s_p0_done, s_p1_done}, 128'd0);
    checkOutput({tag, "_d0"}, s_p0_dout, v.exp_d0);
    checkOutput({tag, "_d1"}, s_p1_dout, v.exp_d1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int port;
    int d0, d1;
    vecs[0] = '{1, 0, 16'h0004, 128'd0,     0, 16'h0000, 100, 0, 0, 16'h0004, DEAD4, 128'd0};
    vecs[1] = '{0, 1, 16'h0010, 128'h1,     0, 16'h0000, 5,   0, 1, 16'h0010, DEAD4, 128'd0};
    vecs[2] = '{0, 0, 16'h0000, 128'd0,     1, 16'h0010, 3,   1, 0, 16'h0010, DEAD4, 128'h1};
    vecs[3] = '{1, 1, 16'h0020, 128'hABC,   0, 16'h0000, 2,   0, 1, 16'h0020, DEAD4, 128'h1};
    vecs[4] = '{0, 0, 16'h0000, 128'd0,     1, 16'h0020, 7,   1, 0, 16'h0020, DEAD4, 128'hABC};

    sel_wd = 0;
    reset = 1;
    mem_ready = 1;
    dropAll();
    p0_addr = '0;
    p1_addr = '0;
    p0_din = '0;
    tick();
    tick();
    preload = 0;
    tick();
    checkOutput("rst_ctrl", {123'd0, a_mem_ren, a_mem_wen, a_p0_done, a_p1_done, a_err}, 128'd0);
    checkOutput("rst_addr_din", {a_mem_din[111:0], a_mem_addr}, 128'd0);
    checkOutput("rst_dout", a_p0_dout | a_p1_dout, 128'd0);
    reset = 0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] contention sequence");
    doReset();
    lat = 4;
    p0_addr = 16'h0004;
    p1_addr = 16'h0010;
    p0_ren = 1;
    p1_ren = 1;
    for (int k = 0; k < 6; k++) begin
      waitDone(60, port);
      checkOutput($sformatf("rr_grant%0d", k), 128'(port), 128'(k % 2));
      if (k > 0) checkOutput($sformatf("rr_gap%0d", k), 128'(last_gap), 128'd2);
      if (k == 5) dropAll();
      else if (port == 0) p0_ren = 0;
      else p1_ren = 0;
      tick();
      if (k < 5) begin
        p0_ren = 1;
        p1_ren = 1;
      end
    end
    checkOutput("rr_overlap", 128'(overlap), 128'd0);
    checkOutput("addr_stable", 128'(unstable), 128'd0);

    $display("[TB] memory not ready");
    tick();
    mem_ready = 0;
    p1_ren = 1;
    p1_addr = 16'h0010;
    lat = 3;
    d0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_ren || s_wen) d0++;
    end
    checkOutput("nrdy_no_strobe", 128'(d0), 128'd0);
    mem_ready = 1;
    tick();
    checkOutput("nrdy_strobe", 128'(s_ren), 128'd1);
    waitDone(20, port);
    dropAll();
    checkOutput("nrdy_port", 128'(port), 128'd1);
    checkOutput("nrdy_d1", s_p1_dout, 128'h1);

    $display("[TB] watchdog instance");
    sel_wd = 1;
    doReset();
    lat = 50;
    p0_addr = 16'h0020;
    p0_ren = 1;
    waitDone(80, port);
    dropAll();
    checkOutput("wd_race_port", 128'(port), 128'd0);
    checkOutput("wd_race_err", 128'(s_err), 128'd0);
    checkOutput("wd_race_d0", s_p0_dout, 128'hABC);
    tick();
    never_done = 1;
    p0_addr = 16'h0010;
    p0_ren = 1;
    waitDone(100, port);
    dropAll();
    checkOutput("wd_port", 128'(port), 128'd0);
    checkOutput("wd_len", 128'(run_len), 128'd50);
    checkOutput("wd_err", 128'(s_err), 128'd1);
    checkOutput("wd_d0_kept", s_p0_dout, 128'hABC);
    tick();
    never_done = 0;
    lat = 3;
    p1_addr = 16'h0010;
    p1_ren = 1;
    waitDone(40, port);
    dropAll();
    checkOutput("wd_next_port", 128'(port), 128'd1);
    checkOutput("wd_next_d1", s_p1_dout, 128'h1);
    checkOutput("wd_sticky", 128'(s_err), 128'd1);

    $display("[TB] reset mid-access");
    sel_wd = 0;
    doReset();
    lat = 100;
    p0_addr = 16'h0004;
    p0_ren = 1;
    for (int i = 0; i < 40 && run_len < 10; i++) tick();
    checkOutput("mid_started", 128'(run_len), 128'd10);
    d0 = done0_cnt;
    d1 = done1_cnt;
    reset = 1;
    tick();
    checkOutput("mid_strobe", {126'd0, s_ren, s_wen}, 128'd0);
    checkOutput("mid_err", 128'(s_err), 128'd0);
    dropAll();
    tick();
    reset = 0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("mid_no_done", 128'((done0_cnt - d0) + (done1_cnt - d1)), 128'd0);
    lat = 3;
    p1_addr = 16'h0010;
    p1_ren = 1;
    waitDone(40, port);
    dropAll();
    checkOutput("mid_after_port", 128'(port), 128'd1);
    checkOutput("mid_after_d1", s_p1_dout, 128'h1);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
